// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl -- run/step sequencer for the multicycle controller.
//
// Turns four asynchronous push-buttons into RUN / RESET requests for the
// controller and watches its state register to find instruction boundaries
// (re-entry to fetch state 4'b0000) and program end (4'b1111).
//
// Optional feature macro: RUN_CTRL_BKPT_EN (instruction-count breakpoint).
//
// Parameters:
//   DB_CYCLES   consecutive equal samples needed to accept a button level
//   CNT_W       width of the retired-instruction counter
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   btn_reset/run/step/halt  asynchronous push-buttons
//   states[3:0]         controller state register
//   bkpt_count, bkpt_en breakpoint target / enable (RUN_CTRL_BKPT_EN only)
//   RUN, RESET          controller run enable and reset request
//   halted              program reached END state
//   busy                sequencer is in FREE or STEP
//   instr_count         instructions retired since last reset (wraps)
//   step_done           one-cycle pulse when a single step completes
//   dbg_state[2:0]      FSM state: 0 IDLE, 1 RSTING, 2 FREE, 3 STEP, 4 HALTED
// -----------------------------------------------------------------------------
module run_ctrl #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_reset,
   input  logic             btn_run,
   input  logic             btn_step,
   input  logic             btn_halt,
   input  logic [3:0]       states,
`ifdef RUN_CTRL_BKPT_EN
   input  logic [CNT_W-1:0] bkpt_count,
   input  logic             bkpt_en,
`endif
   output logic             RUN,
   output logic             RESET,
   output logic             halted,
   output logic             busy,
   output logic [CNT_W-1:0] instr_count,
   output logic             step_done,
   output logic [2:0]       dbg_state
);

   localparam int DB_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RSTING = 3'd1,
      S_FREE   = 3'd2,
      S_STEP   = 3'd3,
      S_HALTED = 3'd4
   } state_e;

   // ---------------------------------------------------------------------------
   // Button conditioning: 2-FF synchroniser, stability counter, rising pulse.
   // Bit order in the vectors: {halt, step, run, reset}.
   // ---------------------------------------------------------------------------
   logic [3:0]            btn_raw;
   logic [3:0]            sync1_q, sync2_q;
   logic [3:0]            level_q;
   logic [3:0][DB_W-1:0]  db_cnt_q;
   logic [3:0]            pulse_q;
   logic                  p_reset, p_run, p_step, p_halt;

   assign btn_raw = {btn_halt, btn_step, btn_run, btn_reset};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         level_q  <= '0;
         db_cnt_q <= '0;
         pulse_q  <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         for (int i = 0; i < 4; i++) begin
            pulse_q[i] <= 1'b0;
            if (sync2_q[i] == level_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
               // DB_CYCLES-th differing sample: accept; pulse only on 0->1.
               level_q[i]  <= sync2_q[i];
               db_cnt_q[i] <= '0;
               pulse_q[i]  <= sync2_q[i];
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign p_reset = pulse_q[0];
   assign p_run   = pulse_q[1];
   assign p_step  = pulse_q[2];
   assign p_halt  = pulse_q[3];

   // ---------------------------------------------------------------------------
   // Sequencer FSM
   // ---------------------------------------------------------------------------
   state_e            state_q, state_d;
   logic              rcnt_q, rcnt_d;     // second RSTING cycle marker
   logic              lf_q, lf_d;         // left_fetch
   logic              stop_q, stop_d;     // halt requested during FREE
   logic [CNT_W-1:0]  count_q, count_d;
   logic              sd_q, sd_d;
   logic              busy_w, at_fetch, is_end, boundary, bkpt_hit, stopping;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RSTING;
         rcnt_q  <= 1'b0;
         lf_q    <= 1'b0;
         stop_q  <= 1'b0;
         count_q <= '0;
         sd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         lf_q    <= lf_d;
         stop_q  <= stop_d;
         count_q <= count_d;
         sd_q    <= sd_d;
      end
   end

   always_comb begin
      busy_w   = (state_q == S_FREE) || (state_q == S_STEP);
      at_fetch = (states == 4'b0000);
      is_end   = (states == 4'b1111);
      // Boundaries only matter while the controller is being run by us.
      boundary = busy_w && lf_q && at_fetch;
`ifdef RUN_CTRL_BKPT_EN
      bkpt_hit = (state_q == S_FREE) && bkpt_en &&
                 ((count_q + CNT_W'(1)) == bkpt_count);
`else
      bkpt_hit = 1'b0;
`endif
      stopping = (state_q == S_STEP) ||
                 ((state_q == S_FREE) && (stop_q || bkpt_hit));
      // Combinational so the controller never leaves fetch on a stopping
      // boundary.
      RUN = (state_q == S_RSTING) || (busy_w && !(boundary && stopping));

      state_d = state_q;
      rcnt_d  = 1'b0;
      lf_d    = lf_q;
      stop_d  = stop_q;
      count_d = count_q;
      sd_d    = 1'b0;

      if (boundary) begin
         lf_d    = 1'b0;
         count_d = count_q + CNT_W'(1);
      end else if (RUN && !at_fetch) begin
         lf_d = 1'b1;
      end
      // Outside FREE/STEP the flag is held clear, so every entry starts clean.
      if (!busy_w) lf_d = 1'b0;

      case (state_q)
         S_RSTING: begin
            if (rcnt_q) state_d = S_IDLE;
            else        rcnt_d  = 1'b1;
         end
         S_IDLE: begin
            if (p_run)       state_d = S_FREE;
            else if (p_step) state_d = S_STEP;
         end
         S_FREE: begin
            if (is_end)                      state_d = S_HALTED;
            else if (boundary && stopping)   state_d = S_IDLE;
            else if (p_halt)                 stop_d  = 1'b1;
         end
         S_STEP: begin
            if (is_end) begin
               state_d = S_HALTED;
            end else if (boundary) begin
               state_d = S_IDLE;
               sd_d    = 1'b1;
            end
         end
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_IDLE;
      endcase

      if (state_d != S_FREE) stop_d = 1'b0;

      // Processor reset overrides everything, including this cycle's boundary.
      if (p_reset) begin
         state_d = S_RSTING;
         rcnt_d  = 1'b0;
         lf_d    = 1'b0;
         stop_d  = 1'b0;
         count_d = '0;
         sd_d    = 1'b0;
      end
   end

   assign RESET       = (state_q == S_RSTING);
   assign halted      = (state_q == S_HALTED);
   assign busy        = busy_w;
   assign instr_count = count_q;
   assign step_done   = sd_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

  localparam int DB_CYCLES = 4;
  localparam int CNT_W     = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RSTING = 3'd1;
  localparam logic [2:0] S_FREE   = 3'd2;
  localparam logic [2:0] S_STEP   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  // button vector order {halt, step, run, reset}
  localparam logic [3:0] B_NONE  = 4'b0000;
  localparam logic [3:0] B_RESET = 4'b0001;
  localparam logic [3:0] B_RUN   = 4'b0010;
  localparam logic [3:0] B_STEP  = 4'b0100;
  localparam logic [3:0] B_HALT  = 4'b1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic btn_reset = 1'b0, btn_run = 1'b0, btn_step = 1'b0, btn_halt = 1'b0;
  logic [3:0] states = 4'b0000;
  logic RUN, RESET, halted, busy, step_done;
  logic [CNT_W-1:0] instr_count;
  logic [2:0] dbg_state;
`ifdef RUN_CTRL_BKPT_EN
  logic [CNT_W-1:0] bkpt_count = '0;
  logic bkpt_en = 1'b0;
`endif

  run_ctrl #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .btn_reset(btn_reset), .btn_run(btn_run), .btn_step(btn_step), .btn_halt(btn_halt),
    .states(states),
`ifdef RUN_CTRL_BKPT_EN
    .bkpt_count(bkpt_count), .bkpt_en(bkpt_en),
`endif
    .RUN(RUN), .RESET(RESET), .halted(halted), .busy(busy),
    .instr_count(instr_count), .step_done(step_done), .dbg_state(dbg_state)
  );

  // ---------------- controller stub ----------------
  // Cycles through seq[] one state per cycle while RUN is high; RESET sends it
  // back to fetch; end_force parks it in the END state.
  logic [3:0] seq [4];
  int seq_len = 2;
  int idx = 0;
  logic end_force = 1'b0;

  initial begin
    logic run_s, rst_s;
    forever begin
      @(negedge clk);
      run_s = RUN;
      rst_s = RESET;
      @(posedge clk);
      #1;
      if (rst_s) begin
        idx = 0;
        end_force = 1'b0;
      end else if (run_s && !end_force) begin
        idx = (idx + 1) % seq_len;
      end
      states = end_force ? 4'b1111 : seq[idx];
    end
  end

  // ---------------- scoreboard / checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int run_hi, rst_hi, sd_cnt, free_ent;
  logic [2:0] prev_st;

  task automatic clr_mon();
    run_hi = 0; rst_hi = 0; sd_cnt = 0; free_ent = 0;
    prev_st = dbg_state;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (RUN) run_hi++;
      if (RESET) rst_hi++;
      if (step_done) sd_cnt++;
      if (dbg_state == S_FREE && prev_st != S_FREE) free_ent++;
      prev_st = dbg_state;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_btns(input logic [3:0] v);
    @(posedge clk);
    #1;
    {btn_halt, btn_step, btn_run, btn_reset} = v;
  endtask

  // Bounded wait; the final comparison doubles as the timeout report.
  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      if (dbg_state == s) break;
      @(negedge clk);
    end
    check(tag, dbg_state, s);
  endtask

  task automatic do_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_state(S_IDLE, 10, "rst_to_idle");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    seq[0] = 4'd0; seq[1] = 4'd5; seq[2] = 4'd0; seq[3] = 4'd0;
    seq_len = 2;
    clr_mon();

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", dbg_state, S_RSTING);
    check("rst_RESET", RESET, 1);
    check("rst_RUN", RUN, 1);
    check("rst_halted", halted, 0);
    check("rst_busy", busy, 0);
    check("rst_count", instr_count, 0);
    check("rst_step_done", step_done, 0);
    wait_state(S_IDLE, 10, "rst_idle");

    // single step through 0 -> 1 -> 3 -> 10 -> 0
    seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd3; seq[3] = 4'd10;
    seq_len = 4;
    clr_mon();
    drive_btns(B_STEP);
    tick(25);
    check("step_run_cycles", run_hi, 4);
    check("step_done_pulses", sd_cnt, 1);
    check("step_count", instr_count, 1);
    check("step_idle", dbg_state, S_IDLE);
    check("step_fetch", states, 0);
    drive_btns(B_NONE);
    tick(10);

    // free run, halt pressed mid 6th instruction (2-cycle instructions)
    seq[0] = 4'd0; seq[1] = 4'd5; seq_len = 2;
    do_rst();
    drive_btns(B_RUN);
    wait_state(S_FREE, 40, "free_entry");
    repeat (5) @(posedge clk);
    #1 btn_run = 1'b0; btn_halt = 1'b1;
    wait_state(S_IDLE, 40, "halt_idle");
    check("halt_count", instr_count, 6);
    check("halt_RUN", RUN, 0);
    drive_btns(B_NONE);
    tick(10);

    // END detection, step ignored while halted, button reset
    do_rst();
    drive_btns(B_RUN);
    wait_state(S_FREE, 40, "end_free");
    end_force = 1'b1;
    @(negedge clk);
    check("end_cycle_RUN", RUN, 1);
    @(negedge clk);
    check("end_halted", halted, 1);
    check("end_RUN", RUN, 0);
    check("end_count", instr_count, 0);
    drive_btns(B_STEP);
    clr_mon();
    tick(20);
    check("halted_step_state", dbg_state, S_HALTED);
    check("halted_step_run", run_hi, 0);
    check("halted_step_done", sd_cnt, 0);
    drive_btns(B_NONE);
    tick(10);
    drive_btns(B_RESET);
    clr_mon();
    tick(20);
    check("breset_cycles", rst_hi, 2);
    check("breset_state", dbg_state, S_IDLE);
    check("breset_count", instr_count, 0);
    check("breset_halted", halted, 0);
    drive_btns(B_NONE);
    tick(10);

    // debounce: 3-cycle press rejected, 4-cycle press accepted
    do_rst();
    clr_mon();
    drive_btns(B_RUN);
    repeat (2) @(posedge clk);
    drive_btns(B_NONE);
    tick(15);
    check("db3_entries", free_ent, 0);
    check("db3_state", dbg_state, S_IDLE);
    clr_mon();
    drive_btns(B_RUN);
    repeat (3) @(posedge clk);
    drive_btns(B_NONE);
    tick(15);
    check("db4_entries", free_ent, 1);
    check("db4_state", dbg_state, S_FREE);

    // 20-cycle hold gives exactly one FREE entry
    do_rst();
    clr_mon();
    drive_btns(B_RUN);
    tick(20);
    drive_btns(B_NONE);
    tick(10);
    check("db20_entries", free_ent, 1);
    check("db20_busy", busy, 1);

    // run and step together in IDLE: run wins
    do_rst();
    clr_mon();
    drive_btns(B_RUN | B_STEP);
    tick(12);
    drive_btns(B_NONE);
    tick(4);
    check("simul_entries", free_ent, 1);
    check("simul_state", dbg_state, S_FREE);

    // halt in IDLE is ignored
    do_rst();
    drive_btns(B_HALT);
    tick(12);
    drive_btns(B_NONE);
    tick(4);
    check("idle_halt_state", dbg_state, S_IDLE);
    check("idle_halt_RUN", RUN, 0);

    // counter wrap: 17 instructions with a 4-bit counter
    do_rst();
    drive_btns(B_RUN);
    wait_state(S_FREE, 40, "wrap_free");
    repeat (27) @(posedge clk);
    #1 btn_run = 1'b0; btn_halt = 1'b1;
    wait_state(S_IDLE, 80, "wrap_idle");
    check("wrap_count", instr_count, 1);
    drive_btns(B_NONE);
    tick(10);

`ifdef RUN_CTRL_BKPT_EN
    // breakpoint at instruction 3
    do_rst();
    bkpt_count = 4'd3;
    bkpt_en = 1'b1;
    drive_btns(B_RUN);
    wait_state(S_FREE, 40, "bkpt_free");
    drive_btns(B_NONE);
    wait_state(S_IDLE, 40, "bkpt_idle");
    check("bkpt_count", instr_count, 3);
    check("bkpt_RUN", RUN, 0);
    bkpt_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
